code_dumper: RTL
================

Name: code_dumper

Overview:
- Reads the program stored in the code RAM and streams it out over the UART transmitter, one byte per UART frame.
- The read-back counterpart of the loader: the loader writes received bytes into code RAM; this block reads them back and transmits them.
- Sits between the code RAM's processor-side read port and the UART data_tx/start_transmit inputs, muxed in by the top level.
- Used to verify a loaded program without running it.

Parameters:
- addrSize_code, 9: code RAM address width; dump covers addresses 0 .. 2^addrSize_code-1.
- GAP_CYCLES, 2000: clk cycles to wait after each startTransmit pulse before the next RAM read. Must be >=1, and sized by the integrator to exceed one UART frame. Counter width is $clog2(GAP_CYCLES+1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- codeIn  in  8  code RAM read data; synchronous RAM, valid one cycle after addrCode
- addrCode  out  addrSize_code  code RAM read address
- dataTx  out  8  byte to transmit; stable from the startTransmit cycle until the next SEND
- startTransmit  out  1  one-cycle pulse: UART latches dataTx
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the dump finishes

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (reset). All outputs are registered.
- Reset (reset==0 at a clk edge) forces:
  - state IDLE
  - addrCode=0, dataTx=0
  - startTransmit=0, busy=0, done=0
  - gap counter=0
- Reset mid-dump aborts the dump immediately. No done pulse. A pending startTransmit is not issued.
- States:
  - IDLE: start==1 -> READ, addrCode=0. start==0 -> stay.
  - READ: addrCode is presented; the RAM registers data. -> CHECK.
  - CHECK: codeIn is valid.
    - codeIn==8'h00 -> FINISH. The terminator byte is not sent.
    - Otherwise -> SEND, with dataTx<=codeIn and startTransmit<=1.
  - SEND: startTransmit high for exactly this cycle. Counter<=GAP_CYCLES-1. -> WAIT.
  - WAIT: counter decrements each cycle. At counter==0:
    - addrCode == all-ones -> FINISH.
    - Otherwise addrCode<=addrCode+1 -> READ.
  - FINISH: done<=1 for one cycle, addrCode<=0. -> IDLE.
- Timing:
  - First startTransmit is high 3 cycles after the edge that samples start.
  - Consecutive startTransmit pulses are exactly GAP_CYCLES+3 cycles apart.
- Boundaries:
  - Empty RAM (address 0 holds 0x00): no transmission; done is high 3 cycles after start is sampled.
  - Full RAM with no terminator: all 2^addrSize_code bytes are sent. addrCode never wraps mid-dump.
  - start while busy: ignored and not queued.
  - start held high across FINISH: a new dump begins on the first IDLE cycle.
- Arithmetic: address increment is plain unsigned. Overflow is impossible because the max address is checked first.

Optional Feature:
- CODE_DUMPER_NEWLINE_EN defined:
  - After the last data byte's WAIT, and on FINISH entry from CHECK, the block first sends 8'h0A through an extra NEWLINE state. NEWLINE behaves like SEND, then WAIT with GAP_CYCLES; the block then goes to FINISH.
  - An empty dump still sends the single 0x0A.
- Undefined: no NEWLINE state; behaviour exactly as above.

Test Plan:
- GAP_CYCLES=4, RAM[0..3]=0x2B,0x2D,0x2E,0x00; pulse start -> startTransmit pulses with dataTx 0x2B,0x2D,0x2E, 7 cycles apart; first pulse 3 cycles after start. done pulses 2 cycles after the third WAIT ends (READ+CHECK of address 3). 0x00 is never sent. busy falls with done.
- RAM[0]=0x00, start -> no startTransmit; done high 3 cycles after start; addrCode=0 afterwards.
- addrSize_code=3, all 8 words nonzero (0x41..0x48) -> 8 pulses carrying 0x41..0x48, then done; addrCode never exceeds 7, returns to 0.
- Pulse start again during WAIT of byte 1 -> ignored; exactly the same 3-byte sequence as scenario 1, single done.
- Drive reset=0 for one cycle during the WAIT after 0x2D -> next cycle busy=0, startTransmit=0, addrCode=0, no done. A following start replays from 0x2B.
- With CODE_DUMPER_NEWLINE_EN, scenario 1 -> 0x2B,0x2D,0x2E,0x0A sent, then done. Empty RAM -> 0x0A only, then done.

Source files
------------

// File: rtl/code_dumper.sv
// Streams the code RAM contents out through the UART, one byte per frame, until
// a 0x00 terminator or the top address. Optional CODE_DUMPER_NEWLINE_EN appends 0x0A.
module code_dumper #(
  parameter int addrSize_code = 9,
  parameter int GAP_CYCLES    = 2000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               codeIn,
  output logic [addrSize_code-1:0] addrCode,
  output logic [7:0]               dataTx,
  output logic                     startTransmit,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

`ifdef CODE_DUMPER_NEWLINE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_SEND, S_WAIT, S_NEWLINE, S_FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_SEND, S_WAIT, S_FINISH
  } state_t;
`endif

  state_t                   state_q, state_d;
  logic [addrSize_code-1:0] addr_q, addr_d;
  logic [7:0]               data_q, data_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     st_q, busy_q, done_q;
`ifdef CODE_DUMPER_NEWLINE_EN
  logic                     nl_q, nl_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef CODE_DUMPER_NEWLINE_EN
    nl_d    = nl_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (codeIn == 8'h00) begin
`ifdef CODE_DUMPER_NEWLINE_EN
          state_d = S_NEWLINE;
`else
          state_d = S_FINISH;
`endif
        end else begin
          state_d = S_SEND;
          data_d  = codeIn;
        end
      end
      S_SEND: begin
        cnt_d   = GAP_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
`ifdef CODE_DUMPER_NEWLINE_EN
          if (nl_q) begin
            state_d = S_FINISH;
          end else if (addr_q == '1) begin
            state_d = S_NEWLINE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
`else
          if (addr_q == '1) begin
            state_d = S_FINISH;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef CODE_DUMPER_NEWLINE_EN
      S_NEWLINE: begin
        cnt_d   = GAP_LOAD;
        nl_d    = 1'b1;
        state_d = S_WAIT;
      end
`endif
      S_FINISH: begin
        addr_d  = '0;
        state_d = S_IDLE;
`ifdef CODE_DUMPER_NEWLINE_EN
        nl_d    = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so transition-dependent values are keyed on state_d.
    if (state_d == S_FINISH) addr_d = '0;
`ifdef CODE_DUMPER_NEWLINE_EN
    if (state_d == S_NEWLINE) data_d = 8'h0A;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CODE_DUMPER_NEWLINE_EN
      nl_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef CODE_DUMPER_NEWLINE_EN
      st_q    <= (state_d == S_SEND) || (state_d == S_NEWLINE);
      nl_q    <= nl_d;
`else
      st_q    <= (state_d == S_SEND);
`endif
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
    end
  end

  assign addrCode      = addr_q;
  assign dataTx        = data_q;
  assign startTransmit = st_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
